// File: rtl/myriadrf_usb_tx_unpack.sv
// myriadrf_usb_tx_unpack
//
// Unpacks the USB host-to-device word stream (three 16-bit words per pair of
// 12-bit IQ samples) into 24-bit samples {I[11:0], Q[11:0]} for the MyriadRF
// TX chain. Everything runs in the wb_clk domain.
//
// Optional build macro: MYRIADRF_USB_TX_TESTPAT_EN
//   When defined, test_pat_i (with enable_i) replaces the USB data with a
//   12-bit ramp presented as {ramp, ~ramp}. When undefined, test_pat_i is
//   ignored and no ramp logic exists.
//
// Ports:
//   wb_clk          block clock
//   wb_rst          synchronous active-high reset
//   enable_i        unpacker enable
//   test_pat_i      selects the ramp generator (testpat build only)
//   usb_s_data_i    USB word
//   usb_s_valid_i   USB word valid
//   usb_s_ready_o   USB word accepted when high together with valid
//   m_data_o        sample, I in [23:12], Q in [11:0]
//   m_valid_o       sample valid
//   m_ready_i       downstream ready
//   sample_cnt_o    samples delivered (valid && ready), wraps modulo 2^32
//   partial_drop_o  one-cycle pulse when a partial sample pair is discarded

module myriadrf_usb_tx_unpack (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        enable_i,
  input  logic        test_pat_i,
  input  logic [15:0] usb_s_data_i,
  input  logic        usb_s_valid_i,
  output logic        usb_s_ready_o,
  output logic [23:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] sample_cnt_o,
  output logic        partial_drop_o
);

  typedef enum logic [1:0] {P0, P1, P2} phase_e;

  phase_e      phase_q, phase_d;
  logic [15:0] residue_q, residue_d;
  logic [23:0] mData_q, mData_d;
  logic        mValid_q, mValid_d;
  logic [31:0] sampleCnt_q, sampleCnt_d;
  logic        partialDrop_q, partialDrop_d;

  logic        testMode;
  logic        accept;
  logic        regDrain;
  logic        delivered;

`ifdef MYRIADRF_USB_TX_TESTPAT_EN
  logic [11:0] ramp_q, ramp_d;

  assign testMode  = test_pat_i & enable_i;
  assign m_valid_o = testMode ? 1'b1 : mValid_q;
  assign m_data_o  = testMode ? {ramp_q, ~ramp_q} : mData_q;

  // The ramp only advances on samples it actually delivers, and keeps its
  // value across leaving test mode.
  always_comb begin
    ramp_d = ramp_q;
    if (testMode && m_ready_i) ramp_d = ramp_q + 12'd1;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) ramp_q <= 12'd0;
    else        ramp_q <= ramp_d;
  end
`else
  // Without the ramp build the select input has no effect.
  assign testMode  = test_pat_i & 1'b0;
  assign m_valid_o = mValid_q;
  assign m_data_o  = mData_q;
`endif

  // W0 never produces a sample, so it can always be taken; W1/W2 need the
  // output register free or emptying this cycle.
  assign usb_s_ready_o = enable_i && !wb_rst && !testMode &&
                         (phase_q == P0 || !mValid_q || m_ready_i);
  assign accept        = usb_s_valid_i && usb_s_ready_o;

  // While the ramp owns the output, a held USB sample is kept, not drained.
  assign regDrain  = mValid_q && m_ready_i && !testMode;
  assign delivered = m_valid_o && m_ready_i;

  assign sample_cnt_o   = sampleCnt_q;
  assign partial_drop_o = partialDrop_q;

  always_comb begin
    phase_d       = phase_q;
    residue_d     = residue_q;
    mData_d       = mData_q;
    mValid_d      = mValid_q;
    partialDrop_d = 1'b0;
    sampleCnt_d   = delivered ? sampleCnt_q + 32'd1 : sampleCnt_q;

    if (regDrain) mValid_d = 1'b0;

    if (!enable_i || testMode) begin
      // Abandon any half-received pair; a held sample stays deliverable.
      phase_d       = P0;
      residue_d     = 16'd0;
      partialDrop_d = (phase_q != P0);
    end else if (accept) begin
      unique case (phase_q)
        P0: begin
          residue_d = usb_s_data_i;
          phase_d   = P1;
        end
        P1: begin
          mData_d   = {residue_q, usb_s_data_i[15:8]};
          mValid_d  = 1'b1;
          residue_d = {8'd0, usb_s_data_i[7:0]};
          phase_d   = P2;
        end
        P2: begin
          mData_d   = {residue_q[7:0], usb_s_data_i};
          mValid_d  = 1'b1;
          residue_d = 16'd0;
          phase_d   = P0;
        end
        default: phase_d = P0;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      phase_q       <= P0;
      residue_q     <= 16'd0;
      mData_q       <= 24'd0;
      mValid_q      <= 1'b0;
      sampleCnt_q   <= 32'd0;
      partialDrop_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      residue_q     <= residue_d;
      mData_q       <= mData_d;
      mValid_q      <= mValid_d;
      sampleCnt_q   <= sampleCnt_d;
      partialDrop_q <= partialDrop_d;
    end
  end

endmodule

// File: tb/tb_myriadrf_usb_tx_unpack.sv
// Testbench for myriadrf_usb_tx_unpack: table of per-cycle vectors plus
// hand-written sequences for counter wrap and (testpat build) the ramp.
module tb_myriadrf_usb_tx_unpack;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        enable_i;
  logic        test_pat_i;
  logic [15:0] usb_s_data_i;
  logic        usb_s_valid_i;
  logic        usb_s_ready_o;
  logic [23:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] sample_cnt_o;
  logic        partial_drop_o;

  int passed = 0;
  int total  = 0;

  always #5 wb_clk = ~wb_clk;

  myriadrf_usb_tx_unpack dut (
    .wb_clk        (wb_clk),
    .wb_rst        (wb_rst),
    .enable_i      (enable_i),
    .test_pat_i    (test_pat_i),
    .usb_s_data_i  (usb_s_data_i),
    .usb_s_valid_i (usb_s_valid_i),
    .usb_s_ready_o (usb_s_ready_o),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .sample_cnt_o  (sample_cnt_o),
    .partial_drop_o(partial_drop_o)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        sv;
    logic [15:0] sd;
    logic        mr;
    logic        expRdy;
    logic        expValid;
    logic [23:0] expData;
    logic [31:0] expCnt;
    logic        expDrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic en, logic sv, logic [15:0] sd,
                              logic mr, logic expRdy, logic expValid,
                              logic [23:0] expData, logic [31:0] expCnt,
                              logic expDrop);
    vec_t v;
    v.rst = rst; v.en = en; v.sv = sv; v.sd = sd; v.mr = mr;
    v.expRdy = expRdy; v.expValid = expValid; v.expData = expData;
    v.expCnt = expCnt; v.expDrop = expDrop;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle: drive inputs, check combinational ready, clock, check outputs.
  task automatic applyStimulus(input vec_t v, input int idx);
    wb_rst        = v.rst;
    enable_i      = v.en;
    usb_s_valid_i = v.sv;
    usb_s_data_i  = v.sd;
    m_ready_i     = v.mr;
    #1;
    checkOutput($sformatf("v%0d ready", idx), {31'd0, usb_s_ready_o}, {31'd0, v.expRdy});
    @(posedge wb_clk);
    #1;
    checkOutput($sformatf("v%0d valid", idx), {31'd0, m_valid_o}, {31'd0, v.expValid});
    if (v.expValid || v.rst)
      checkOutput($sformatf("v%0d data", idx), {8'd0, m_data_o}, {8'd0, v.expData});
    checkOutput($sformatf("v%0d cnt", idx), sample_cnt_o, v.expCnt);
    checkOutput($sformatf("v%0d drop", idx), {31'd0, partial_drop_o}, {31'd0, v.expDrop});
  endtask

  initial begin
    wb_rst = 1'b1; enable_i = 1'b0; test_pat_i = 1'b0;
    usb_s_data_i = 16'd0; usb_s_valid_i = 1'b0; m_ready_i = 1'b0;

    //             rst en sv  data      mr rdy vld data       cnt drop
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 0, 24'h000000, 0, 0));
    // packing
    vecs.push_back(mk(0, 1, 1, 16'h1232, 1, 1, 0, 24'h000000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h34AB, 1, 1, 1, 24'h123234, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'hC789, 1, 1, 1, 24'hABC789, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 0, 24'h000000, 2, 0));
    // backpressure on W2
    vecs.push_back(mk(0, 1, 1, 16'h1232, 1, 1, 0, 24'h000000, 2, 0));
    vecs.push_back(mk(0, 1, 1, 16'h34AB, 0, 1, 1, 24'h123234, 2, 0));
    vecs.push_back(mk(0, 1, 1, 16'hC789, 0, 0, 1, 24'h123234, 2, 0));
    vecs.push_back(mk(0, 1, 1, 16'hC789, 1, 1, 1, 24'hABC789, 3, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 0, 24'h000000, 4, 0));
    // partial drop after W0, then clean pair
    vecs.push_back(mk(0, 1, 1, 16'h1232, 1, 1, 0, 24'h000000, 4, 0));
    vecs.push_back(mk(0, 0, 1, 16'h34AB, 1, 0, 0, 24'h000000, 4, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 24'h000000, 4, 0));
    vecs.push_back(mk(0, 1, 1, 16'hFFF0, 1, 1, 0, 24'h000000, 4, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0080, 1, 1, 1, 24'hFFF000, 4, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0800, 1, 1, 1, 24'h800800, 5, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 0, 24'h000000, 6, 0));
    // enable falls in the same cycle as a W1 offer
    vecs.push_back(mk(0, 1, 1, 16'h1111, 1, 1, 0, 24'h000000, 6, 0));
    vecs.push_back(mk(0, 0, 1, 16'h2222, 1, 0, 0, 24'h000000, 6, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 24'h000000, 6, 0));
    // held sample still delivered while disabled
    vecs.push_back(mk(0, 1, 1, 16'hAAAA, 0, 1, 0, 24'h000000, 6, 0));
    vecs.push_back(mk(0, 1, 1, 16'hBBBB, 0, 1, 1, 24'hAAAABB, 6, 0));
    vecs.push_back(mk(0, 0, 1, 16'hCCCC, 0, 0, 1, 24'hAAAABB, 6, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 24'h000000, 7, 0));
    // reset mid-pair with a sample pending, then a clean pair
    vecs.push_back(mk(0, 1, 1, 16'h1232, 0, 1, 0, 24'h000000, 7, 0));
    vecs.push_back(mk(0, 1, 1, 16'h34AB, 0, 1, 1, 24'h123234, 7, 0));
    vecs.push_back(mk(1, 1, 1, 16'hC789, 0, 0, 0, 24'h000000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h1232, 1, 1, 0, 24'h000000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h34AB, 1, 1, 1, 24'h123234, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'hC789, 1, 1, 1, 24'hABC789, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 1, 0, 24'h000000, 2, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Counter wrap: hold a sample, preload the counter, then deliver.
    usb_s_valid_i = 1'b1; usb_s_data_i = 16'h5555; m_ready_i = 1'b0;
    @(posedge wb_clk); #1;
    usb_s_data_i = 16'h6666;
    @(posedge wb_clk); #1;
    usb_s_valid_i = 1'b0;
    force dut.sampleCnt_q = 32'hFFFF_FFFF;
    @(posedge wb_clk); #1;
    release dut.sampleCnt_q;
    checkOutput("wrap held valid", {31'd0, m_valid_o}, 32'd1);
    checkOutput("wrap held data", {8'd0, m_data_o}, 32'h00555566);
    m_ready_i = 1'b1;
    @(posedge wb_clk); #1;
    checkOutput("wrap cnt", sample_cnt_o, 32'h0000_0000);
    checkOutput("wrap valid", {31'd0, m_valid_o}, 32'd0);

`ifdef MYRIADRF_USB_TX_TESTPAT_EN
    begin
      logic [11:0] r;
      r = 12'd0;
      test_pat_i = 1'b1; enable_i = 1'b1; m_ready_i = 1'b1;
      usb_s_valid_i = 1'b1;
      for (int n = 0; n < 4097; n++) begin
        #1;
        if (n < 3 || n > 4093) begin
          checkOutput($sformatf("ramp%0d rdy", n), {31'd0, usb_s_ready_o}, 32'd0);
          checkOutput($sformatf("ramp%0d valid", n), {31'd0, m_valid_o}, 32'd1);
        end
        checkOutput($sformatf("ramp%0d data", n), {8'd0, m_data_o}, {8'd0, r, ~r});
        @(posedge wb_clk); #1;
        r = r + 12'd1;
      end
      test_pat_i = 1'b0; usb_s_valid_i = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
